// File: rtl/multi_countdown_timer_if.sv
// Memory-bus slave port of the multi-channel countdown timer.
// The CPU side drives select, address, write data and lane enables; the timer returns a one-cycle acknowledge and read data.
interface multi_countdown_timer_if;
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data_i;
    logic [3:0]  we;
    logic        ready;
    logic [31:0] data_o;

    modport master (output sel, addr, data_i, we, input ready, data_o);
    modport slave  (input sel, addr, data_i, we, output ready, data_o);
endinterface

// File: rtl/multi_countdown_timer.sv
// NUM_CH independent WIDTH-bit down-counters (one-shot/periodic, sticky expiry, irq enable) behind a byte-lane memory-bus slave.
// Access: ready one cycle after sel rises; write commits at the end of that cycle; sel held high just parks the FSM in HOLD.
module multi_countdown_timer #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multi_countdown_timer_if.slave bus,
    output logic                   irq
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t state, state_nxt;

    logic [5:0]       ch_idx;
    logic [1:0]       reg_idx;
    logic             wr_en;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rdata;
    logic [31:0]      rd_ch [NUM_CH];
    logic [NUM_CH-1:0] expired;
    logic [NUM_CH-1:0] irq_en;
    logic             unused_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.ready   = 1'b0;
        bus.data_o  = '0;
        case (state)
            IDLE: if (bus.sel) state_nxt = ACK;
            ACK: begin
                state_nxt  = bus.sel ? HOLD : IDLE;
                bus.ready  = 1'b1;
                bus.data_o = rdata;
            end
            HOLD: if (!bus.sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ch_idx    = bus.addr[7:2];
    assign reg_idx   = bus.addr[1:0];
    assign wr_en     = (state == ACK) && (bus.we != 4'b0000);
    assign lane_mask = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
    // Slicing to WIDTH drops data bits and whole lanes that lie above the counter.
    assign wmask     = lane_mask[WIDTH-1:0];
    assign wdata     = bus.data_i[WIDTH-1:0];
    assign unused_bits = ^{bus.data_i, lane_mask};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] reload;
        logic [2:0]       ctrl;
        logic             exp_q;
        logic             hit;
        logic             cnt_wr;
        logic             tick;
        logic             last;

        assign hit    = wr_en && (ch_idx == 6'(c));
        assign cnt_wr = hit && (reg_idx == 2'd0);
        assign last   = (count == WIDTH'(1));
        // A bus write to COUNT pre-empts the decrement for that cycle.
        assign tick   = ctrl[0] && (count != '0) && !cnt_wr;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                count  <= '0;
                reload <= '0;
                ctrl   <= '0;
                exp_q  <= 1'b0;
            end else begin
                if (cnt_wr)
                    count <= (count & ~wmask) | (wdata & wmask);
                else if (tick)
                    count <= last ? (ctrl[1] ? reload : '0) : count - 1'b1;

                if (hit && reg_idx == 2'd1)
                    reload <= (reload & ~wmask) | (wdata & wmask);

                if (hit && reg_idx == 2'd2 && bus.we[0])
                    ctrl <= bus.data_i[2:0];

                // Expiry beats a simultaneous write-1-to-clear.
                if (tick && last)
                    exp_q <= 1'b1;
                else if (hit && reg_idx == 2'd3 && bus.we[0] && bus.data_i[0])
                    exp_q <= 1'b0;
            end
        end

        assign rd_ch[c]   = (reg_idx == 2'd0) ? 32'(count)  :
                            (reg_idx == 2'd1) ? 32'(reload) :
                            (reg_idx == 2'd2) ? 32'(ctrl)   : 32'(exp_q);
        assign expired[c] = exp_q;
        assign irq_en[c]  = ctrl[2];
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (ch_idx == 6'(c)) rdata = rd_ch[c];
    end

    assign irq = |(expired & irq_en);

endmodule

// File: doc/multi_countdown_timer.md
Name: multi_countdown_timer

Overview:
- Parametrised, multi-channel successor to the single countdown timer.
- Provides NUM_CH independent down-counters of WIDTH bits, each with one-shot or periodic (auto-reload) mode, a sticky expiry flag and a per-channel interrupt enable.
- Sits on the CPU memory bus as a slave with byte-lane writes, and drives one combined interrupt line to the core.

Parameters:
- NUM_CH, 2: number of timer channels, 1..64.
- WIDTH, 32: counter and reload width in bits, 1..32.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- sel  input  1  bus select; held high until the access completes
- addr  input  8  word address: channel = addr[7:2], register = addr[1:0]
- data_i  input  32  write data, little-endian byte lanes
- we  input  4  byte-lane write enables; all zero means read
- ready  output  1  one-cycle access acknowledge
- data_o  output  32  read data
- irq  output  1  combined interrupt

Behaviour:
- Reset is asynchronous, active-low (reset_n), on clock clk.
- Reset values: all COUNT, RELOAD, CTRL and STATUS registers are 0; ready=0, irq=0, data_o=0.
- Register map per channel (word index):
  - 0 COUNT: read/write.
  - 1 RELOAD: read/write.
  - 2 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - 3 STATUS: bit0 EXPIRED, write-1-to-clear via lane 0; other bits read 0.
- Width rules:
  - Reads are zero-extended from WIDTH to 32 bits.
  - Written bits at or above WIDTH are discarded.
  - A byte lane lying wholly above WIDTH is ignored.
- Unmapped addresses (channel >= NUM_CH): read 0, writes ignored, still acknowledged.
- Bus handshake FSM:
  - States: IDLE, ACK, HOLD.
  - IDLE -> ACK when sel=1.
  - ACK -> HOLD if sel=1, else -> IDLE.
  - HOLD -> IDLE when sel=0.
  - ready=1 only in ACK, so there is exactly one ready pulse per access, one cycle after sel rises.
  - data_o shows the addressed register during ACK and is 0 otherwise.
  - A write commits on the clock edge that ends ACK. Each access therefore writes exactly once, even if sel stays high.
  - sel dropping during ACK aborts nothing: the write still commits.
- Per-channel counting, evaluated every clk:
  - If a bus write hits this channel's COUNT this cycle, the enabled lanes take data_i and the unwritten lanes hold their current value. No decrement occurs that cycle.
  - Else if EN=0 or COUNT=0: hold.
  - Else if COUNT=1: set EXPIRED. COUNT <= RELOAD if PERIODIC=1, else 0. PERIODIC with RELOAD=0 ends at 0 and stops.
  - Else: COUNT <= COUNT-1.
- Resulting period: with PERIODIC=1 and RELOAD=R (R>=1), EXPIRED sets every R cycles.
- Write to RELOAD never disturbs COUNT; the new value is used at the next expiry.
- STATUS: if an expiry and a W1C land in the same cycle, set wins and EXPIRED stays 1. Writing 0 has no effect.
- irq = OR over channels of (EXPIRED & IRQ_EN). It is combinational from flops, with no extra latency beyond the EXPIRED flop.
- Channels are fully independent, and simultaneous expiries on several channels are all recorded.
- Asserting reset_n low mid-access or mid-count returns everything to reset values immediately. The FSM resumes in IDLE, and a still-high sel after reset starts a new access.

Test Plan:
- Reset/idle: release reset_n, no sel -> all reads return 0; ready never asserts without sel; irq=0.
- Handshake: hold sel=1 for 6 cycles, we=0, addr=0x01 -> ready high only in cycle 2. Write COUNT with sel held 6 cycles -> value written once and not re-written.
- One-shot: ch0 COUNT=5, CTRL=0x5 -> EXPIRED and irq rise 5 cycles after the CTRL commit; COUNT stays 0. W1C STATUS=1 -> irq drops the next cycle.
- Periodic: ch1 (addr 0x04) RELOAD=3, COUNT=3, CTRL=0x3 -> EXPIRED sets every 3 cycles. W1C coinciding with an expiry -> EXPIRED remains 1.
- Byte lanes/width: with WIDTH=12, COUNT=0xABC, write we=4'b0010, data_i=0x0000_0500 -> COUNT=0x5BC. Write 0xFFFF_FFFF, we=4'hF -> reads 0x0000_0FFF.
- Unmapped/independence: NUM_CH=2, write addr 0x08 -> ready pulses, read 0. Two channels expiring in the same cycle -> both EXPIRED set; irq reflects only the IRQ_EN channels.
